fetch_ctrl: RTL and testbench

- Sequences the program counter and the instruction-memory fetch port for the IF stage of the 5-stage pipeline.
- Chooses the next PC (sequential, branch/jump redirect, exception vector) and runs a single-outstanding-request handshake with instruction memory.
- Holds the fetched instruction in a one-entry output buffer until the IF/ID register accepts it.
- Handles stalls and flushes, including redirects that arrive while a request is in flight.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/fetch_ctrl_if.sv | 37 +++
 rtl/fetch_ctrl_buf.sv | 56 +++++
 rtl/fetch_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the IF-stage fetch controller:
//   - fetch_state_e   : fetch FSM state encoding (IDLE / REQ / WAIT)
//   - RESET_VECTOR_DEFAULT / EXC_VECTOR_DEFAULT : default PC vectors
//   - PC_INCR         : sequential PC step (one 32-bit instruction word)
//   - word_misaligned : true when an address is not word aligned
// ---------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT   = 32'h8000_0180;
    localparam int unsigned PC_INCR              = 4;

    // Instructions are 32-bit words, so any set low address bit is misaligned.
    function automatic logic word_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
// Instruction-memory fetch port (single outstanding request).
//   req    : fetch request (fetch side -> memory)
//   addr   : fetch address  (fetch side -> memory)
//   gnt    : request accepted this cycle (memory -> fetch side)
//   rvalid : read data valid, at least one cycle after gnt (memory -> fetch side)
//   rdata  : instruction word (memory -> fetch side)
// Modports: master = fetch controller, slave = instruction memory.
// ---------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/fetch_ctrl_buf.sv
// ---------------------------------------------------------------------------
// fetch_buf
// One-entry output buffer between instruction fetch and the IF/ID register.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   flush       : redirect/exception this cycle, invalidates the entry
//   load        : a kept instruction returns this cycle
//   stall       : downstream cannot accept, entry is held
//   load_instr  : returned instruction word
//   load_pc     : PC of the returned instruction
//   valid       : entry holds an instruction
//   instr / pc  : buffered instruction and its PC
// Priority: rst > flush > load > consume (stall low).
// ---------------------------------------------------------------------------
module fetch_buf #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic              stall,
    input  logic [31:0]       load_instr,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc
);

    logic              valid_reg;
    logic [31:0]       instr_reg;
    logic [ADDR_W-1:0] pc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            instr_reg <= '0;
            pc_reg    <= '0;
        end else if (flush) begin
            // A flush beats a stall: the held instruction is on the wrong path.
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            instr_reg <= load_instr;
            pc_reg    <= load_pc;
        end else if (!stall) begin
            // Downstream took the entry; instr/pc keep their last value.
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign instr = instr_reg;
    assign pc    = pc_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// IF-stage program counter sequencer and instruction-memory fetch controller.
// Chooses the next PC (sequential, redirect, exception vector), runs a
// single-outstanding request/grant/rvalid handshake and hands fetched words to
// a one-entry output buffer (fetch_buf).
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   stall_i         : IF/ID cannot accept; buffered instruction held
//   redirect_i      : branch/jump taken, target on redirect_pc_i
//   exc_i           : exception, highest priority, target EXC_VECTOR
//   imem            : fetch_ctrl_if.master (req/addr out, gnt/rvalid/rdata in)
//   if_valid        : if_instr/if_pc valid
//   if_instr, if_pc : buffered instruction and its PC
//   pc              : current fetch PC (also driven on imem.addr)
//   misalign_o      : one-cycle pulse when a misaligned redirect is trapped
//
// Build option FETCH_MISALIGN_TRAP_EN:
//   defined   - a redirect target with bits[1:0] != 0 is replaced by
//               EXC_VECTOR and misalign_o pulses for one cycle
//   undefined - redirect target bits[1:0] are forced to 00, misalign_o = 0
// ---------------------------------------------------------------------------
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEFAULT),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(EXC_VECTOR_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              exc_i,
    fetch_ctrl_if.master      imem,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              misalign_o
);

    localparam logic [1:0] S_IDLE = FETCH_IDLE;
    localparam logic [1:0] S_REQ  = FETCH_REQ;
    localparam logic [1:0] S_WAIT = FETCH_WAIT;

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              drop_reg, drop_next;

    logic              buf_valid;
    logic              issue;          // request actually driven to memory
    logic              granted;        // request accepted this cycle
    logic              resp;           // the outstanding response returns now
    logic              redirect_any;
    logic              buf_load;
    logic [ADDR_W-1:0] redirect_target;

    // -----------------------------------------------------------------------
    // Redirect target selection (exception > redirect)
    // -----------------------------------------------------------------------
`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_next;
    logic misalign_reg;

    always_comb begin
        redirect_target = redirect_pc_i;
        misalign_next   = 1'b0;
        if (exc_i) begin
            // Exception vectors are trusted and never checked.
            redirect_target = EXC_VECTOR;
        end else if (redirect_i && word_misaligned(redirect_pc_i[1:0])) begin
            redirect_target = EXC_VECTOR;
            misalign_next   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= misalign_next;
        end
    end

    assign misalign_o = misalign_reg;
`else
    always_comb begin
        // Silently word-align the redirect target.
        redirect_target = redirect_pc_i & ~ADDR_W'(3);
        if (exc_i) begin
            redirect_target = EXC_VECTOR;
        end
    end

    assign misalign_o = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Handshake qualifiers
    // -----------------------------------------------------------------------
    // A new fetch may only start when its result will have somewhere to go:
    // the buffer is empty or is being drained this cycle.
    assign issue        = (state_reg == S_REQ) && (!buf_valid || !stall_i);
    assign granted      = issue && imem.gnt;
    assign resp         = (state_reg == S_WAIT) && imem.rvalid;
    assign redirect_any = exc_i || redirect_i;
    // Returned data is kept only if it is not stale and no redirect kills it.
    assign buf_load     = resp && !drop_reg && !redirect_any;

    // -----------------------------------------------------------------------
    // Next-state / next-PC logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        drop_next  = drop_reg;

        case (state_reg)
            S_IDLE: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                if (granted) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp) begin
                    state_next = S_REQ;
                    drop_next  = 1'b0;
                    if (!drop_reg) begin
                        pc_next = pc_reg + ADDR_W'(PC_INCR);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (redirect_any) begin
            pc_next = redirect_target;
            // A response still owed by memory belongs to the old path: wait
            // for it and throw it away. If it returns this very cycle the
            // handshake is already complete and fetching can restart.
            if (((state_reg == S_WAIT) && !resp) || granted) begin
                drop_next  = 1'b1;
                state_next = S_WAIT;
            end else begin
                drop_next  = 1'b0;
                state_next = S_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            pc_reg    <= RESET_VECTOR;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            drop_reg  <= drop_next;
        end
    end

    // -----------------------------------------------------------------------
    // Output buffer
    // -----------------------------------------------------------------------
    fetch_buf #(
        .ADDR_W (ADDR_W)
    ) u_fetch_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_any),
        .load       (buf_load),
        .stall      (stall_i),
        .load_instr (imem.rdata),
        .load_pc    (pc_reg),
        .valid      (buf_valid),
        .instr      (if_instr),
        .pc         (if_pc)
    );

    assign if_valid  = buf_valid;
    assign imem.req  = issue;
    assign imem.addr = pc_reg;
    assign pc        = pc_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Drives fetch_ctrl with directed steps followed by a randomized phase.
// A memory responder grants requests and returns addr-derived words after a
// configurable latency. The reference model describes the instruction stream
// seen by IF/ID: every instruction taken from the buffer must be the next
// sequential word since the last reset/redirect/exception target.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;
    import mips_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] EV = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        exc_i;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] pc;
    logic        misalign_o;

    fetch_ctrl_if #(.ADDR_W(32)) imem_bus ();

    fetch_ctrl #(
        .ADDR_W       (32),
        .RESET_VECTOR (RV),
        .EXC_VECTOR   (EV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .exc_i         (exc_i),
        .imem          (imem_bus),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .pc            (pc),
        .misalign_o    (misalign_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // memory responder state
    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          gnt_pct;
    int          lat_min;
    int          lat_max;
    logic        gnt_block;

    // pre-edge samples of the last tick
    logic        s_req;
    logic        s_gnt;
    logic [31:0] s_addr;

    // reference model
    logic [31:0] exp_pc;
    logic        exp_mis;
    int          consumed;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16]};
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
        return (t % 4 != 0) ? EV : t;
`else
        return t - (t % 4);
`endif
    endfunction

    function automatic logic model_mis(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
        return (t % 4 != 0);
`else
        return (t === 32'hx);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, expv);
    endtask

    // One clock cycle: memory reacts, the model digests the cycle, the edge
    // happens, then registered outputs settle for the caller to inspect.
    task automatic tick();
        logic rv;
        logic g;
        #1;
        rv = mem_pend && (mem_cnt == 0);
        imem_bus.rvalid = rv;
        imem_bus.rdata  = rv ? mem_word(mem_addr) : $urandom();
        #1;
        g = imem_bus.req && !mem_pend && !gnt_block && ($urandom_range(0, 99) < gnt_pct);
        imem_bus.gnt = g;
        #1;
        s_req  = imem_bus.req;
        s_addr = imem_bus.addr;
        s_gnt  = g;
        if (s_req) chk("single_outstanding", {31'd0, mem_pend}, 32'd0);

        if (rst) begin
            exp_pc  = RV;
            exp_mis = 1'b0;
        end else if (exc_i) begin
            exp_pc  = EV;
            exp_mis = 1'b0;
        end else if (redirect_i) begin
            exp_pc  = model_target(redirect_pc_i);
            exp_mis = model_mis(redirect_pc_i);
        end else begin
            exp_mis = 1'b0;
            if (if_valid && !stall_i) begin
                chk("stream_pc", if_pc, exp_pc);
                chk("stream_instr", if_instr, mem_word(exp_pc));
                exp_pc = exp_pc + 4;
                consumed++;
            end
        end

        @(posedge clk);
        if (rv) mem_pend = 1'b0;
        else if (mem_pend && mem_cnt > 0) mem_cnt--;
        if (g) begin
            mem_pend = 1'b1;
            mem_addr = s_addr;
            mem_cnt  = $urandom_range(lat_min, lat_max) - 1;
        end
        #1;
        chk("misalign_o", {31'd0, misalign_o}, {31'd0, exp_mis});
    endtask

    task automatic wait_gnt(input string tag);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!s_gnt && k < 30);
        chk(tag, {31'd0, s_gnt}, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        do begin
            tick();
            k++;
        end while (if_valid !== 1'b1 && k < 30);
        chk(tag, {31'd0, if_valid}, 32'd1);
    endtask

    initial begin
        int start_consumed;
        int r;

        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; exc_i = 1'b0;
        redirect_pc_i = 32'h0;
        imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = 32'h0;
        mem_pend = 1'b0; mem_cnt = 0; mem_addr = 32'h0;
        gnt_pct = 100; lat_min = 1; lat_max = 1; gnt_block = 1'b0;
        exp_pc = RV; exp_mis = 1'b0; consumed = 0;

        // reset state
        tick(); tick();
        chk("rst_pc", pc, RV);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_imem_req", {31'd0, imem_bus.req}, 32'd0);
        rst = 1'b0;

        // zero-wait memory: one instruction every second cycle
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("zw_if_valid", {31'd0, if_valid}, (k >= 3 && k % 2 == 1) ? 32'd1 : 32'd0);
        end
        chk("zw_if_pc_8", if_pc, 32'h8);

        // stall with a full buffer: hold, no request
        stall_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_if_pc", if_pc, 32'h8);
            chk("stall_if_instr", if_instr, mem_word(32'h8));
            chk("stall_no_req", {31'd0, s_req}, 32'd0);
        end
        stall_i = 1'b0;

        // grant withheld: request and address stay stable
        gnt_block = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("nogt_req", {31'd0, s_req}, 32'd1);
            chk("nogt_addr", s_addr, 32'hC);
        end
        gnt_block = 1'b0;
        wait_gnt("gnt_c");
        chk("gnt_c_addr", s_addr, 32'hC);
        wait_valid("valid_c");
        chk("valid_c_pc", if_pc, 32'hC);

        // redirect while waiting for 0x10, with stall asserted
        lat_min = 3; lat_max = 3;
        wait_gnt("gnt_10");
        chk("gnt_10_addr", s_addr, 32'h10);
        redirect_i = 1'b1; redirect_pc_i = 32'h100; stall_i = 1'b1;
        tick();
        chk("redir_flush", {31'd0, if_valid}, 32'd0);
        chk("redir_pc", pc, 32'h100);
        redirect_i = 1'b0; stall_i = 1'b0;
        lat_min = 1; lat_max = 1;
        wait_valid("valid_100");
        chk("valid_100_pc", if_pc, 32'h100);
        chk("valid_100_instr", if_instr, mem_word(32'h100));

        // exception and redirect together flush a stalled buffer
        stall_i = 1'b1;
        tick();
        chk("held_100", {31'd0, if_valid}, 32'd1);
        exc_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200;
        tick();
        chk("exc_flush", {31'd0, if_valid}, 32'd0);
        chk("exc_pc", pc, EV);
        exc_i = 1'b0; redirect_i = 1'b0; stall_i = 1'b0;
        wait_valid("valid_exc");
        chk("valid_exc_pc", if_pc, EV);

        // PC wrap at the top of the address space
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        wait_valid("valid_top");
        chk("valid_top_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc", pc, 32'h0);
        wait_valid("valid_wrap");
        chk("valid_wrap_pc", if_pc, 32'h0);

        // reset while waiting; the late response must be ignored
        lat_min = 2; lat_max = 2;
        wait_gnt("gnt_pre_rst");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_pc", pc, RV);
        chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        lat_min = 1; lat_max = 1;
        tick();
        chk("stale_ignored", {31'd0, if_valid}, 32'd0);
        wait_valid("valid_after_rst");
        chk("after_rst_pc", if_pc, RV);
        chk("after_rst_instr", if_instr, mem_word(RV));

        // misaligned redirect target
        redirect_i = 1'b1; redirect_pc_i = 32'h102;
        tick();
        redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_pc", pc, EV);
        chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
`else
        chk("mis_pc", pc, 32'h100);
        chk("mis_pulse", {31'd0, misalign_o}, 32'd0);
`endif
        tick();
        chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0);

        // randomized phase
        gnt_pct = 60; lat_min = 1; lat_max = 3;
        start_consumed = consumed;
        for (int k = 0; k < 600; k++) begin
            stall_i       = ($urandom_range(0, 99) < 30);
            r             = $urandom_range(0, 99);
            exc_i         = (r < 2);
            redirect_i    = (r >= 2 && r < 6);
            redirect_pc_i = $urandom() & 32'h0000_0FFF;
            tick();
        end
        stall_i = 1'b0; exc_i = 1'b0; redirect_i = 1'b0;
        chk("random_progress", {31'd0, (consumed - start_consumed) > 30}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
